// File: rtl/layernorm_hls_deadlock_detect_unit_v2.sv
// Per-process deadlock detection node for the layernorm HLS dataflow region.
// It merges dependence vectors from the input channels and forwards its own
// dependence downstream. It flags a deadlock when its own bit comes back
// around the graph for CONFIRM_CYCLES consecutive cycles. A latched report
// record (channel mask, dependence, timestamp) is offered once per episode
// with a valid/ack handshake.
//
// Ports
//   clock, reset           rising-edge clock, synchronous active-high reset
//   proc_dep_vld_vec       this process is blocked on output channel j
//   in_chan_dep_vld_vec    dependence data valid per input channel
//   in_chan_dep_data_vec   channel i vector at [i*PROC_NUM +: PROC_NUM]
//   token_in_vec           report token arriving per input channel
//   dl_detect_in           a deadlock is already flagged globally
//   origin                 this node originates the report token
//   token_clear            drop the incoming token this cycle
//   report_ack             consumer accepts the report record
//   out_chan_dep_vld_vec   dependence valid per output channel (comb)
//   out_chan_dep_data      dependence vector sent downstream
//   token_out_vec          report token forwarded per output channel
//   dl_detect_out          confirmed deadlock (comb)
//   dl_report_*            report record and its valid flag
module layernorm_hls_deadlock_detect_unit_v2 #(
  parameter int unsigned PROC_NUM       = 4,
  parameter int unsigned PROC_ID        = 0,
  parameter int unsigned IN_CHAN_NUM    = 2,
  parameter int unsigned OUT_CHAN_NUM   = 3,
  parameter int unsigned CONFIRM_CYCLES = 8,
  parameter int unsigned TS_WIDTH       = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
  input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
  input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
  input  logic                            dl_detect_in,
  input  logic                            origin,
  input  logic                            token_clear,
  input  logic                            report_ack,
  output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
  output logic [PROC_NUM-1:0]             out_chan_dep_data,
  output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
  output logic                            dl_detect_out,
  output logic                            dl_report_vld,
  output logic [OUT_CHAN_NUM-1:0]         dl_report_chan_mask,
  output logic [PROC_NUM-1:0]             dl_report_dep,
  output logic [TS_WIDTH-1:0]             dl_report_cycle
);

  localparam int unsigned CNT_W = $clog2(CONFIRM_CYCLES + 1);
  localparam int unsigned CMP_W = CNT_W + 1;
  localparam logic [PROC_NUM-1:0] SELF_BIT = PROC_NUM'(1) << PROC_ID;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REPORT = 2'd1,
    S_HOLD   = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [PROC_NUM-1:0]       dep_q, dep_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [TS_WIDTH-1:0]       ts_q, ts_d;
  logic [OUT_CHAN_NUM-1:0]   tok_q, tok_d;
  logic                      vld_q, vld_d;
  logic [OUT_CHAN_NUM-1:0]   mask_q;
  logic [PROC_NUM-1:0]       rdep_q;
  logic [TS_WIDTH-1:0]       rcyc_q;

  logic [PROC_NUM-1:0]       dep_comb, dep;
  logic                      gate, blocked, raw, confirmed, capture;

  // Dependence merge, raw detection and persistence filter.
  always_comb begin
    dep_comb = '0;
    for (int i = 0; i < int'(IN_CHAN_NUM); i++) begin
      if (in_chan_dep_vld_vec[i]) begin
        dep_comb = dep_comb | in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
      end
    end
    // Once a deadlock is flagged globally, only a passing token refreshes dep.
    gate      = ~dl_detect_in | (|token_in_vec);
    blocked   = |proc_dep_vld_vec;
    dep       = gate ? dep_comb : dep_q;
    raw       = gate & (|(dep & SELF_BIT)) & blocked;
    // cnt counts prior consecutive raw cycles; this cycle makes cnt+1.
    confirmed = raw & ((CMP_W'(cnt_q) + CMP_W'(1)) >= CMP_W'(CONFIRM_CYCLES));

    dep_d = blocked ? dep : '0;
    if (!raw) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(CONFIRM_CYCLES)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    ts_d  = ts_q + TS_WIDTH'(1);
    // origin overrides token_clear.
    tok_d = (((|token_in_vec) & ~token_clear) | origin) ? proc_dep_vld_vec : '0;
  end

  // Report FSM: one record per deadlock episode.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (confirmed) begin
          capture = 1'b1;
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        if (report_ack) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!raw) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    vld_d = (state_d == S_REPORT);
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      dep_q   <= '0;
      cnt_q   <= '0;
      ts_q    <= '0;
      tok_q   <= '0;
      vld_q   <= 1'b0;
      mask_q  <= '0;
      rdep_q  <= '0;
      rcyc_q  <= '0;
    end else begin
      state_q <= state_d;
      dep_q   <= dep_d;
      cnt_q   <= cnt_d;
      ts_q    <= ts_d;
      tok_q   <= tok_d;
      vld_q   <= vld_d;
      if (capture) begin
        mask_q <= proc_dep_vld_vec;
        rdep_q <= dep;
        rcyc_q <= ts_q;
      end
    end
  end

  assign out_chan_dep_vld_vec = proc_dep_vld_vec;
  assign out_chan_dep_data    = dep_q | SELF_BIT;
  assign token_out_vec        = tok_q;
  assign dl_detect_out        = confirmed;
  assign dl_report_vld        = vld_q;
  assign dl_report_chan_mask  = mask_q;
  assign dl_report_dep        = rdep_q;
  assign dl_report_cycle      = rcyc_q;

endmodule

// File: tb/tb_layernorm_hls_deadlock_detect_unit_v2.sv
// Bench for layernorm_hls_deadlock_detect_unit_v2: two instances share one
// stimulus stream (CONFIRM=8/PROC_ID=0/TS=32 and CONFIRM=1/PROC_ID=2/TS=4)
// and are compared every cycle against a run-length based reference model.
module tb_layernorm_hls_deadlock_detect_unit_v2;

  logic       clock;
  logic       reset;
  logic [2:0] pdv;
  logic [1:0] ivld;
  logic [7:0] idata;
  logic [1:0] tin;
  logic       dli, origin, clr, ack;

  logic [2:0]  a_ovld, a_tok, a_mask;
  logic [3:0]  a_odata, a_rdep;
  logic        a_det, a_rvld;
  logic [31:0] a_rcyc;
  logic [2:0]  b_ovld, b_tok, b_mask;
  logic [3:0]  b_odata, b_rdep;
  logic        b_det, b_rvld;
  logic [3:0]  b_rcyc;

  layernorm_hls_deadlock_detect_unit_v2 #(
    .PROC_NUM(4), .PROC_ID(0), .IN_CHAN_NUM(2), .OUT_CHAN_NUM(3),
    .CONFIRM_CYCLES(8), .TS_WIDTH(32)
  ) dut_a (
    .clock(clock), .reset(reset), .proc_dep_vld_vec(pdv),
    .in_chan_dep_vld_vec(ivld), .in_chan_dep_data_vec(idata),
    .token_in_vec(tin), .dl_detect_in(dli), .origin(origin),
    .token_clear(clr), .report_ack(ack),
    .out_chan_dep_vld_vec(a_ovld), .out_chan_dep_data(a_odata),
    .token_out_vec(a_tok), .dl_detect_out(a_det), .dl_report_vld(a_rvld),
    .dl_report_chan_mask(a_mask), .dl_report_dep(a_rdep),
    .dl_report_cycle(a_rcyc)
  );

  layernorm_hls_deadlock_detect_unit_v2 #(
    .PROC_NUM(4), .PROC_ID(2), .IN_CHAN_NUM(2), .OUT_CHAN_NUM(3),
    .CONFIRM_CYCLES(1), .TS_WIDTH(4)
  ) dut_b (
    .clock(clock), .reset(reset), .proc_dep_vld_vec(pdv),
    .in_chan_dep_vld_vec(ivld), .in_chan_dep_data_vec(idata),
    .token_in_vec(tin), .dl_detect_in(dli), .origin(origin),
    .token_clear(clr), .report_ack(ack),
    .out_chan_dep_vld_vec(b_ovld), .out_chan_dep_data(b_odata),
    .token_out_vec(b_tok), .dl_detect_out(b_det), .dl_report_vld(b_rvld),
    .dl_report_chan_mask(b_mask), .dl_report_dep(b_rdep),
    .dl_report_cycle(b_rcyc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests;
  int fails;

  // Reference model state, one slot per instance.
  int         m_conf[2];
  int         m_pid[2];
  int         m_tsw[2];
  logic [3:0] m_dep[2],  n_dep[2];
  int         m_run[2],  n_run[2];   // consecutive raw cycles so far
  longint     m_ts[2],   n_ts[2];
  logic [2:0] m_tok[2],  n_tok[2];
  bit         m_vld[2],  n_vld[2];   // record offered
  bit         m_done[2], n_done[2];  // episode already reported
  logic [2:0] m_mask[2], n_mask[2];
  logic [3:0] m_rdep[2], n_rdep[2];
  longint     m_rcyc[2], n_rcyc[2];

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_dep[k] = '0; m_run[k] = 0; m_ts[k] = 0; m_tok[k] = '0;
      m_vld[k] = 0; m_done[k] = 0; m_mask[k] = '0; m_rdep[k] = '0; m_rcyc[k] = 0;
    end
  endtask

  // One clock cycle: check both instances mid-cycle, then advance the model.
  task automatic tick();
    logic [3:0]  dc, dep;
    bit          gate, blocked, raw, cf;
    logic [63:0] o_det, o_ovld, o_odata, o_tok, o_rvld, o_mask, o_rdep, o_rcyc;
    @(negedge clock);
    #1;
    dc = '0;
    if (ivld[0]) dc = dc | idata[3:0];
    if (ivld[1]) dc = dc | idata[7:4];
    gate    = !dli || (tin != 2'b00);
    blocked = (pdv != 3'b000);
    for (int k = 0; k < 2; k++) begin
      dep = gate ? dc : m_dep[k];
      raw = gate && dep[m_pid[k]] && blocked;
      cf  = raw && (m_run[k] + 1 >= m_conf[k]);
      if (k == 0) begin
        o_det = 64'(a_det); o_ovld = 64'(a_ovld); o_odata = 64'(a_odata); o_tok = 64'(a_tok);
        o_rvld = 64'(a_rvld); o_mask = 64'(a_mask); o_rdep = 64'(a_rdep); o_rcyc = 64'(a_rcyc);
      end else begin
        o_det = 64'(b_det); o_ovld = 64'(b_ovld); o_odata = 64'(b_odata); o_tok = 64'(b_tok);
        o_rvld = 64'(b_rvld); o_mask = 64'(b_mask); o_rdep = 64'(b_rdep); o_rcyc = 64'(b_rcyc);
      end
      chk("dl_detect_out", k, o_det, 64'(cf));
      chk("out_chan_dep_vld_vec", k, o_ovld, 64'(pdv));
      chk("out_chan_dep_data", k, o_odata, 64'(m_dep[k] | (4'd1 << m_pid[k])));
      chk("token_out_vec", k, o_tok, 64'(m_tok[k]));
      chk("dl_report_vld", k, o_rvld, 64'(m_vld[k]));
      chk("dl_report_chan_mask", k, o_mask, 64'(m_mask[k]));
      chk("dl_report_dep", k, o_rdep, 64'(m_rdep[k]));
      chk("dl_report_cycle", k, o_rcyc, 64'(m_rcyc[k]));

      if (reset) begin
        n_dep[k] = '0; n_run[k] = 0; n_ts[k] = 0; n_tok[k] = '0;
        n_vld[k] = 0; n_done[k] = 0; n_mask[k] = '0; n_rdep[k] = '0; n_rcyc[k] = 0;
      end else begin
        n_dep[k]  = blocked ? dep : 4'd0;
        n_run[k]  = raw ? ((m_run[k] < 100) ? m_run[k] + 1 : m_run[k]) : 0;
        n_ts[k]   = (m_ts[k] + 1) & ((64'd1 << m_tsw[k]) - 1);
        n_tok[k]  = (((tin != 2'b00) && !clr) || origin) ? pdv : 3'd0;
        n_vld[k]  = m_vld[k];
        n_done[k] = m_done[k];
        n_mask[k] = m_mask[k];
        n_rdep[k] = m_rdep[k];
        n_rcyc[k] = m_rcyc[k];
        if (!m_done[k] && cf) begin
          n_vld[k] = 1; n_done[k] = 1;
          n_mask[k] = pdv; n_rdep[k] = dep; n_rcyc[k] = m_ts[k];
        end else if (m_vld[k] && ack) begin
          n_vld[k] = 0;
        end else if (m_done[k] && !m_vld[k] && !raw) begin
          n_done[k] = 0;
        end
      end
    end
    @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_dep[k] = n_dep[k]; m_run[k] = n_run[k]; m_ts[k] = n_ts[k]; m_tok[k] = n_tok[k];
      m_vld[k] = n_vld[k]; m_done[k] = n_done[k]; m_mask[k] = n_mask[k];
      m_rdep[k] = n_rdep[k]; m_rcyc[k] = n_rcyc[k];
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    tests = 0; fails = 0;
    m_conf[0] = 8; m_pid[0] = 0; m_tsw[0] = 32;
    m_conf[1] = 1; m_pid[1] = 2; m_tsw[1] = 4;
    reset = 1'b1; pdv = '0; ivld = '0; idata = '0; tin = '0;
    dli = 1'b0; origin = 1'b0; clr = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    model_clear();
    tick();                       // reset state
    reset = 1'b0;

    // Deadlock loop present: chan0 carries bits 0 and 2.
    ivld = 2'b01; idata = 8'h05; pdv = 3'b001;
    ticks(7);                     // 7 raw cycles: filtered node stays quiet
    ivld = 2'b00; ticks(1);       // raw drops, counter restarts
    ivld = 2'b01; pdv = 3'b101;
    ticks(8);                     // 8th raw cycle confirms
    ticks(5);                     // record held without ack
    ack = 1'b1; ticks(1); ack = 1'b0;
    ticks(4);                     // still raw: no second report
    ivld = 2'b00; ticks(1);
    ivld = 2'b01; ticks(9);       // new episode, second report
    ack = 1'b1; ticks(1); ack = 1'b0;

    // Global flag set: dep frozen unless a token passes.
    dli = 1'b1; tin = 2'b00; idata = 8'h0A; ticks(3);
    tin = 2'b01; clr = 1'b0; ticks(2);
    clr = 1'b1; ticks(2);
    origin = 1'b1; ticks(2);
    origin = 1'b0; clr = 1'b0; tin = 2'b00; dli = 1'b0;

    // Reset in the middle of a report.
    idata = 8'h05; ivld = 2'b11; pdv = 3'b110;
    ticks(10);
    reset = 1'b1; ticks(1); reset = 1'b0;
    ticks(10);
    ack = 1'b1; ticks(2); ack = 1'b0;

    // Randomized segments with inputs held for a few cycles each.
    for (int s = 0; s < 700; s++) begin
      int len;
      len    = int'($urandom_range(1, 12));
      pdv    = ($urandom_range(0, 4) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      ivld   = 2'($urandom);
      idata  = 8'($urandom);
      if ($urandom_range(0, 3) != 0) idata[2:0] = idata[2:0] | 3'b101;
      dli    = ($urandom_range(0, 3) == 0);
      tin    = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom);
      origin = ($urandom_range(0, 7) == 0);
      clr    = ($urandom_range(0, 3) == 0);
      reset  = ($urandom_range(0, 99) == 0);
      for (int c = 0; c < len; c++) begin
        ack = ($urandom_range(0, 2) == 0);
        tick();
        reset = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
